keypad_key_buffer: RTL and testbench
====================================

Name: keypad_key_buffer

Overview:
- Sits directly downstream of Hex_Keypad_Encoder; consumes its Code/Valid outputs.
- Qualifies each key press: Valid must hold with a stable Code for DEBOUNCE_CYCLES.
- Produces exactly one event per physical press and queues events in a DEPTH-entry FIFO.
- A consumer (UART/display logic) drains the FIFO over a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles Valid=1 with an unchanged Code before a press is accepted (>=1).
- RELEASE_CYCLES, 4, consecutive cycles Valid=0 before a press is considered released (>=1).
- DEPTH, 8, FIFO entries; power of two, >=2.

Ports:
- clock  input  1  single system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- Code  input  4  encoded key from Hex_Keypad_Encoder.
- Valid  input  1  key-detected flag from Hex_Keypad_Encoder.
- key_code  output  4  code at the FIFO head.
- key_valid  output  1  FIFO non-empty.
- key_ready  input  1  consumer accepts the head when key_valid&key_ready.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a qualified press was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; counters=0; FIFO empty; key_code=0; key_valid=0; level=0; overflow=0.
- Qualification FSM, states IDLE, QUALIFY, HELD, RELEASE_WAIT:
  - IDLE: Valid=1 -> latch Code into cand, cnt=1, go QUALIFY.
  - QUALIFY:
    - Valid=0 -> IDLE (press discarded).
    - Code!=cand -> re-latch cand, cnt=1, stay.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES: push cand on that edge and go HELD.
    - With DEBOUNCE_CYCLES=1, the push happens on the edge after IDLE sees Valid.
  - HELD:
    - Valid=1 -> stay; Code changes are ignored (no auto-repeat, no second event).
    - Valid=0 -> RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT:
    - Valid=1 -> HELD (bounce; no new event).
    - Otherwise cnt++. When cnt reaches RELEASE_CYCLES -> IDLE.
- Latency: a push on edge N gives key_valid=1 and key_code=cand after edge N if the FIFO was empty.
- FIFO:
  - Storage is registered; pointers are $clog2(DEPTH) bits with natural wrap.
  - level is the registered occupancy, range 0..DEPTH.
  - pop = key_valid & key_ready.
  - push & pop with 0<level<DEPTH -> level unchanged, both pointers advance.
  - push when level=DEPTH and pop in the same cycle -> push accepted (the pop frees a slot), level stays DEPTH.
  - push when level=DEPTH and no pop -> entry dropped, overflow set to 1 next edge.
  - pop when empty -> impossible by construction (key_valid=0); key_ready is ignored.
  - push when empty: the entry is not visible to pop in the same cycle.
- overflow: stays set until clr_overflow=1. If a set and a clear happen in the same cycle, set wins.
- key_code holds its last value when empty; the verifier checks it only when key_valid=1.
- Reset mid-press or mid-handshake: all state is cleared immediately. After reset release, a still-held key re-qualifies from IDLE and produces a new event.

Decomposition:
- Shared package keypad_pkg:
  - FSM state encoding: IDLE=2'd0, QUALIFY=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3.
  - CODE_W=4.
  - Default DEBOUNCE/RELEASE constants.
- Sub-module key_fifo holds the generic DEPTH x CODE_W synchronous FIFO: push, pop, full, empty, level, and the async active-low reset.
- keypad_key_buffer keeps the FSM, the counters, and the overflow logic.

Test Plan:
- Press code 4'h5 with Valid=1 for 10 cycles, key_ready=1 -> exactly one key_valid pulse with key_code=5, appearing 4 edges after Valid rose (defaults).
- Valid=1 for 3 cycles, 0 for 2, then 1 for 3 -> no event (debounce never completes); level stays 0.
- Press 4'hA held 6 cycles, then Valid drops 2 cycles, then returns for 5 cycles -> single event A (bounce absorbed in RELEASE_WAIT).
- key_ready=0; 9 distinct qualified presses 0..8 separated by 5 idle cycles -> level=8, overflow=1. Then set key_ready=1 -> pops 0..7 in order, and code 8 is absent.
- With level=8 and key_ready=1, a press completes in the same cycle as a pop -> level stays 8, overflow stays 0, and the new code appears last.
- Assert reset=0 mid-QUALIFY and with level=3 -> on that edge key_valid=0, level=0, overflow=0. After release with Valid still 1 and Code=C, a new event C appears after 4 cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad key buffer: FSM state encoding,
// code width and default timing constants.
package keypad_pkg;

    localparam int CODE_W           = 4;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int RELEASE_DEFAULT  = 4;
    localparam int DEPTH_DEFAULT    = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        QUALIFY      = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO with a registered head output and
// registered occupancy; a pop on a full FIFO frees a slot for a same-cycle push.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = CODE_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [LVL_W-1:0]  count;
    logic [LVL_W-1:0]  count_nxt;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] head_nxt;
    logic              pop_ok;
    logic              push_ok;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head of the FIFO after this edge; a push into an otherwise empty FIFO
    // bypasses storage so the new entry is visible right after the edge.
    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(pop_ok);
        count_nxt  = count + LVL_W'(push_ok) - LVL_W'(pop_ok);
        head_nxt   = mem[rd_ptr_nxt];
        if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                head <= head_nxt;
            end
        end
    end

    assign rd_data = head;
    assign level   = count;

endmodule

// File: rtl/keypad_key_buffer.sv
// Debounces the keypad encoder's Code/Valid into one event per physical press
// and queues the events in a FIFO drained over a valid/ready handshake.
module keypad_key_buffer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int RELEASE_CYCLES  = RELEASE_DEFAULT,
    parameter int DEPTH           = DEPTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CODE_W-1:0]      Code,
    input  logic                   Valid,
    output logic [CODE_W-1:0]      key_code,
    output logic                   key_valid,
    input  logic                   key_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int CNT_W = $clog2(max2(DEBOUNCE_CYCLES, RELEASE_CYCLES) + 2);
    localparam logic [CNT_W-1:0] DEB_TGT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REL_TGT = CNT_W'(RELEASE_CYCLES);

    key_state_t        state;
    key_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CODE_W-1:0] cand;
    logic [CODE_W-1:0] cand_nxt;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (Valid) begin
                    cand_nxt  = Code;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = QUALIFY;
                end
            end
            QUALIFY: begin
                if (!Valid) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (Code != cand) begin
                    cand_nxt = Code;
                    cnt_nxt  = CNT_W'(1);
                end else if (cnt_inc >= DEB_TGT) begin
                    push      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            // Code changes while held are ignored: one event per press, no repeat.
            HELD: begin
                if (!Valid) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (Valid) begin
                    cnt_nxt   = '0;
                    state_nxt = HELD;
                end else if (cnt_inc >= REL_TGT) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clock) begin
        cand <= cand_nxt;
    end

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    assign drop = push & fifo_full & ~(key_valid & key_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CODE_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (cand),
        .pop     (key_ready),
        .rd_data (key_code),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign key_valid = ~fifo_empty;

endmodule

// File: tb/tb_keypad_key_buffer.sv
// Scoreboard bench for keypad_key_buffer: a run-length press model feeds an
// expected-event queue that a negedge monitor compares against the DUT.
module tb_keypad_key_buffer;

    localparam int DEB      = 4;
    localparam int REL      = 4;
    localparam int DEPTH    = 8;
    localparam int NEED_DEB = (DEB < 2) ? 2 : DEB;
    localparam int NEED_REL = (REL < 2) ? 2 : REL;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Code = 4'h0;
    logic       Valid = 1'b0;
    logic       key_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] level;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int seen  = 0;

    always #5 clock = ~clock;

    keypad_key_buffer #(
        .DEBOUNCE_CYCLES (DEB),
        .RELEASE_CYCLES  (REL),
        .DEPTH           (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .Code         (Code),
        .Valid        (Valid),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a press is counted by run lengths of stable Valid/Code,
    // and re-arms after enough consecutive Valid=0 samples.
    logic [3:0] exp_q[$];
    int         m_level = 0;
    bit         exp_ovf = 1'b0;
    bit         armed = 1'b1;
    int         run = 0;
    logic [3:0] run_code = 4'h0;
    int         zeros = 0;
    bit         ev;
    logic [3:0] ev_code;
    bit         m_pop;
    bit         m_drop;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_level = 0;
            exp_ovf = 1'b0;
            armed   = 1'b1;
            run     = 0;
            zeros   = 0;
        end else begin
            ev = 1'b0;
            ev_code = 4'h0;
            if (armed) begin
                if (Valid) begin
                    if (run > 0 && Code == run_code) run++;
                    else begin
                        run = 1;
                        run_code = Code;
                    end
                    if (run >= NEED_DEB) begin
                        ev = 1'b1;
                        ev_code = run_code;
                        armed = 1'b0;
                        zeros = 0;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
            end else if (Valid) begin
                zeros = 0;
            end else begin
                zeros++;
                if (zeros >= NEED_REL) armed = 1'b1;
            end
            m_pop  = (m_level > 0) && key_ready;
            m_drop = 1'b0;
            if (ev) begin
                if (m_level < DEPTH || m_pop) begin
                    exp_q.push_back(ev_code);
                    m_level++;
                end else begin
                    m_drop = 1'b1;
                end
            end
            if (m_pop) m_level--;
            if (m_drop) exp_ovf = 1'b1;
            else if (clr_overflow) exp_ovf = 1'b0;
        end
    end

    always @(negedge clock) begin
        check("level", 32'(level), 32'(m_level));
        check("key_valid", 32'(key_valid), 32'(m_level > 0));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        if (key_valid && key_ready) seen++;
        if (exp_q.size() > 0) begin
            if (key_valid) check("key_code", 32'(key_code), 32'(exp_q[0]));
            if (key_ready) void'(exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic press(input logic [3:0] c, input int hold, input int gap);
        Code  = c;
        Valid = 1'b1;
        tick(hold);
        Valid = 1'b0;
        tick(gap);
    endtask

    int base;

    initial begin
        #1 reset = 1'b0;
        tick(2);
        check("rst_level", 32'(level), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_key_code", 32'(key_code), 0);
        reset = 1'b1;
        key_ready = 1'b1;
        tick(1);

        // Single press of 5: visible exactly after the 4th sampling edge.
        base = seen;
        Code = 4'h5;
        Valid = 1'b1;
        tick(3);
        check("lat_before", 32'(key_valid), 0);
        tick(1);
        check("lat_valid", 32'(key_valid), 1);
        check("lat_code", 32'(key_code), 32'h5);
        tick(6);
        Valid = 1'b0;
        tick(6);
        check("single_event", 32'(seen - base), 1);

        // Short bursts never complete debounce.
        base = seen;
        Code = 4'h3;
        Valid = 1'b1;
        tick(3);
        Valid = 1'b0;
        tick(2);
        Valid = 1'b1;
        tick(3);
        Valid = 1'b0;
        tick(6);
        check("no_event", 32'(seen - base), 0);
        check("no_event_level", 32'(level), 0);

        // Release bounce absorbed.
        base = seen;
        Code = 4'hA;
        Valid = 1'b1;
        tick(6);
        Valid = 1'b0;
        tick(2);
        Valid = 1'b1;
        tick(5);
        Valid = 1'b0;
        tick(6);
        check("bounce_single", 32'(seen - base), 1);

        // Overflow: 9 presses into a stalled FIFO.
        key_ready = 1'b0;
        for (int i = 0; i < 9; i++) press(4'(i), 6, 5);
        check("ovf_level", 32'(level), 8);
        check("ovf_flag", 32'(overflow), 1);
        base = seen;
        key_ready = 1'b1;
        tick(12);
        check("ovf_drained", 32'(seen - base), 8);
        check("ovf_sticky", 32'(overflow), 1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Push and pop on the same edge with a full FIFO.
        key_ready = 1'b0;
        for (int i = 1; i <= 8; i++) press(4'(i), 6, 5);
        check("full_level", 32'(level), 8);
        base = seen;
        Code = 4'h9;
        Valid = 1'b1;
        tick(3);
        key_ready = 1'b1;
        tick(1);
        check("full_pp_level", 32'(level), 8);
        check("full_pp_ovf", 32'(overflow), 0);
        Valid = 1'b0;
        tick(14);
        check("full_pp_count", 32'(seen - base), 9);

        // Reset mid-QUALIFY with three queued entries.
        key_ready = 1'b0;
        for (int i = 1; i <= 3; i++) press(4'(i), 6, 5);
        check("pre_rst_level", 32'(level), 3);
        Code = 4'hC;
        Valid = 1'b1;
        tick(2);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(key_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        tick(2);
        reset = 1'b1;
        key_ready = 1'b1;
        tick(3);
        check("post_rst_early", 32'(key_valid), 0);
        tick(1);
        check("post_rst_valid", 32'(key_valid), 1);
        check("post_rst_code", 32'(key_code), 32'hC);
        Valid = 1'b0;
        tick(6);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) Valid = ~Valid;
            if ($urandom_range(0, 15) == 0) Code = 4'($urandom_range(0, 15));
            key_ready = ($urandom_range(0, 3) == 0);
            clr_overflow = ($urandom_range(0, 31) == 0);
            tick(1);
        end
        Valid = 1'b0;
        clr_overflow = 1'b0;
        key_ready = 1'b1;
        tick(20);
        check("drain_empty", 32'(exp_q.size()), 0);
        check("drain_valid", 32'(key_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
